alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0, which sets the requester holding priority after reset (0 or 1).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port req0_valid, input, 1 bit: requester 0 has an operation pending.
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester 0 operation accepted this cycle.
REQ-006 The block SHALL have ports req0_op (input, 4 bits), req0_a (input, 8 bits) and req0_b (input, 8 bits), carrying the opcode and operands of requester 0.
REQ-007 The block SHALL have port rsp0_valid, output, 1 bit: a response for requester 0 is present.
REQ-008 The block SHALL have port rsp0_ready, input, 1 bit: requester 0 takes the response.
REQ-009 The block SHALL have ports rsp0_r (output, 8 bits), rsp0_flags (output, 3 bits, {N,Z,V}) and rsp0_err (output, 1 bit: illegal opcode).
REQ-010 The block SHALL have req1_* and rsp1_* ports identical to the req0_* and rsp0_* ports, for requester 1.
REQ-011 The block SHALL have ports alu_op (output, 4 bits), alu_a (output, 8 bits) and alu_b (output, 8 bits), which drive the shared ALU.
REQ-012 The block SHALL have ports alu_r (input, 8 bits) and alu_flags (input, 3 bits), which carry the combinational result of the shared ALU.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, EXEC, RESP.
REQ-015 In IDLE, when exactly one reqN_valid is high, that requester SHALL be granted.
REQ-016 In IDLE, when both reqN_valid are high, the requester named by the priority bit SHALL be granted.
REQ-017 reqN_ready SHALL be high only in IDLE and only for the granted requester; it may depend combinationally on both valids.
REQ-018 Requesters SHALL NOT make valid depend on ready; once raised, valid and its op, a and b SHALL hold stable until ready.
REQ-019 On a handshake (valid and ready), the block SHALL register the grant ID, op, a and b.
REQ-020 On a handshake, the priority bit SHALL be set to the non-granted requester, including single-requester grants.
REQ-021 On a handshake, the state SHALL go IDLE -> EXEC.
REQ-022 Legal opcodes SHALL be 4'b0001-4'b1101 and 4'b1111.
REQ-023 Illegal opcodes SHALL be 4'b0000 and 4'b1110.
REQ-024 In EXEC with a legal op, alu_op, alu_a and alu_b SHALL carry the registered values.
REQ-025 At the end of EXEC with a legal op, alu_r and alu_flags SHALL be captured into the granted rsp registers, with err=0.
REQ-026 In EXEC with an illegal op, alu_* SHALL keep their previous values.
REQ-027 For an illegal op, the captured response SHALL be r=8'h00, flags=3'b010, err=1.
REQ-028 EXEC SHALL last exactly one cycle, then go to RESP.
REQ-029 In RESP, the granted rspN_valid SHALL be high; the other rsp valid SHALL be low.
REQ-030 In RESP, rspN_r, rspN_flags and rspN_err SHALL be held stable.
REQ-031 In RESP, when rspN_ready is high, rspN_valid SHALL drop next cycle and state SHALL return to IDLE.
REQ-032 Back-pressure SHALL be unbounded: RESP holds while rspN_ready is low, and no new request is accepted.
REQ-033 Latency SHALL be: handshake at cycle T, EXEC at T+1, rspN_valid at T+2.
REQ-034 Minimum issue interval SHALL be 3 cycles when rsp ready is held high.
REQ-035 A request arriving in EXEC or RESP SHALL wait; no request SHALL be dropped.
REQ-036 After a completed transaction, the waiting requester wins if both are valid.
REQ-037 The rspN data registers SHALL hold their last value when not selected; only rspN_valid qualifies them.
REQ-038 rspN_ready asserted while rspN_valid is low SHALL be ignored.

Reset
REQ-039 While rst_n is low, state SHALL be IDLE and priority SHALL be RR_INIT.
REQ-040 While rst_n is low, all outputs SHALL be 0 (req*_ready, rsp*_valid, rsp*_r, rsp*_flags, rsp*_err, alu_*, busy).
REQ-041 Reset asserted in EXEC or RESP SHALL abandon the transaction with no response.
REQ-042 The first request SHALL be accepted in the first cycle after rst_n deasserts.

Verification
REQ-043 Scenario: req0 op=4'b1000 a=8'h05 b=8'h03, rsp0_ready=1 -> alu_op=1000 at T+1; rsp0_valid at T+2 with r=8'h08, flags=3'b000, err=0; busy high T+1..T+2.
REQ-044 Scenario: RR_INIT=0, both valid at reset release, req0 SUB 8'h03-8'h05, req1 AND 8'hF0&8'h0F -> rsp0 first with r=8'hFE, flags=3'b100; rsp1 next with r=8'h00, flags=3'b010; req1_ready exactly 3 cycles after req0_ready.
REQ-045 Scenario: rsp1_ready held low 5 cycles after rsp1_valid -> rsp1_valid and data stable for 6 cycles; req0_ready stays low throughout although req0_valid=1.
REQ-046 Scenario: req0 op=4'b1110 after an ADD -> alu_* unchanged from the ADD; rsp0 r=8'h00, flags=3'b010, err=1.
REQ-047 Scenario: rst_n pulsed low during EXEC of a req1 op -> all outputs 0 immediately, no rsp1_valid ever, priority=RR_INIT; a new req1 is accepted the cycle after release.
REQ-048 Scenario: req1 alone, 4 back-to-back ops -> every op granted, priority stays 0 after each, issue interval 3 cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end sharing one external combinational ALU between two requesters.
// Each transaction walks IDLE -> EXEC -> RESP; responses are held until the owner takes them.
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_r,
    output logic [2:0] rsp0_flags,
    output logic       rsp0_err,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_r,
    output logic [2:0] rsp1_flags,
    output logic       rsp1_err,
    output logic [3:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_r,
    input  logic [2:0] alu_flags,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q;
    logic       prio_q, gnt_q, ill_q;
    logic [3:0] alu_op_q;
    logic [7:0] alu_a_q, alu_b_q;
    logic [7:0] r_q [2];
    logic [2:0] flags_q [2];
    logic [1:0] err_q;
    logic       gnt1, hs, in_ill;
    logic [3:0] in_op;
    logic [7:0] in_a, in_b;

    // Ready is masked by rst_n so no grant is visible while reset is asserted.
    assign gnt1       = req1_valid && (!req0_valid || prio_q);
    assign req0_ready = rst_n && state_q == IDLE && req0_valid && !gnt1;
    assign req1_ready = rst_n && state_q == IDLE && gnt1;
    assign hs         = req0_ready || req1_ready;
    assign in_op      = gnt1 ? req1_op : req0_op;
    assign in_a       = gnt1 ? req1_a : req0_a;
    assign in_b       = gnt1 ? req1_b : req0_b;
    assign in_ill     = in_op == 4'h0 || in_op == 4'he;

    assign busy       = state_q != IDLE;
    assign rsp0_valid = state_q == RESP && !gnt_q;
    assign rsp1_valid = state_q == RESP && gnt_q;
    assign rsp0_r     = r_q[0];
    assign rsp1_r     = r_q[1];
    assign rsp0_flags = flags_q[0];
    assign rsp1_flags = flags_q[1];
    assign rsp0_err   = err_q[0];
    assign rsp1_err   = err_q[1];
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prio_q     <= RR_INIT;
            gnt_q      <= 1'b0;
            ill_q      <= 1'b0;
            alu_op_q   <= 4'h0;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            r_q[0]     <= 8'h00;
            r_q[1]     <= 8'h00;
            flags_q[0] <= 3'b000;
            flags_q[1] <= 3'b000;
            err_q      <= 2'b00;
        end else begin
            case (state_q)
                IDLE: if (hs) begin
                    state_q <= EXEC;
                    gnt_q   <= gnt1;
                    prio_q  <= !gnt1;
                    ill_q   <= in_ill;
                    // Illegal ops leave the ALU bus untouched.
                    if (!in_ill) begin
                        alu_op_q <= in_op;
                        alu_a_q  <= in_a;
                        alu_b_q  <= in_b;
                    end
                end
                EXEC: begin
                    state_q         <= RESP;
                    r_q[gnt_q]      <= ill_q ? 8'h00 : alu_r;
                    flags_q[gnt_q]  <= ill_q ? 3'b010 : alu_flags;
                    err_q[gnt_q]    <= ill_q;
                end
                RESP: if (gnt_q ? rsp1_ready : rsp0_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model of the arbiter and an external reference ALU.
module tb_alu_arbiter;
    logic       clk, rst_n;
    logic       req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
    logic       req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
    logic [3:0] req0_op, req1_op, alu_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, rsp0_r, rsp1_r, alu_a, alu_b, alu_r;
    logic [2:0] rsp0_flags, rsp1_flags, alu_flags;
    logic       busy;
    int         total = 0, bad = 0, n = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_r(rsp0_r), .rsp0_flags(rsp0_flags), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_r(rsp1_r), .rsp1_flags(rsp1_flags), .rsp1_err(rsp1_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_flags(alu_flags), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: result followed by {N,Z,V}.
    function automatic logic [10:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic       v;
        v = 1'b0;
        case (op)
            4'h8: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'h9: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'ha: r = a & b;
            4'hb: r = a | b;
            4'hc: r = a ^ b;
            default: r = (a + {op, 4'h0}) ^ b;
        endcase
        return {r, r[7], r == 8'h00, v};
    endfunction

    assign {alu_r, alu_flags} = alu_ref(alu_op, alu_a, alu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: at most one pending job, aged 0 (executing) or 1 (responding).
    bit         m_pend, m_id, m_prio, g, legal;
    int         m_age;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;
    logic [19:0] m_last;
    logic [10:0] res;
    logic [7:0] m_r [2];
    logic [2:0] m_f [2];
    logic       m_e [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_age = 0; m_id = 0; m_prio = 0; m_last = '0;
            m_op = 0; m_a = 0; m_b = 0;
            m_r = '{8'h00, 8'h00}; m_f = '{3'b000, 3'b000}; m_e = '{1'b0, 1'b0};
        end else if (!m_pend) begin
            if (req0_valid || req1_valid) begin
                g = (req0_valid && req1_valid) ? m_prio : req1_valid;
                m_pend = 1; m_age = 0; m_id = g; m_prio = !g;
                m_op = g ? req1_op : req0_op;
                m_a = g ? req1_a : req0_a;
                m_b = g ? req1_b : req0_b;
            end
        end else if (m_age == 0) begin
            legal = !(m_op == 4'h0 || m_op == 4'he);
            res = legal ? alu_ref(m_op, m_a, m_b) : {8'h00, 3'b010};
            m_r[m_id] = res[10:3]; m_f[m_id] = res[2:0]; m_e[m_id] = !legal;
            if (legal) m_last = {m_op, m_a, m_b};
            m_age = 1;
        end else if (m_id ? rsp1_ready : rsp0_ready) begin
            m_pend = 0;
        end
    end

    always @(negedge clk) begin
        chk("req0_ready", req0_ready, rst_n && !m_pend && req0_valid && (!req1_valid || !m_prio));
        chk("req1_ready", req1_ready, rst_n && !m_pend && req1_valid && (!req0_valid || m_prio));
        chk("busy", busy, m_pend);
        chk("rsp0_valid", rsp0_valid, m_pend && m_age == 1 && !m_id);
        chk("rsp1_valid", rsp1_valid, m_pend && m_age == 1 && m_id);
        chk("rsp0_data", {rsp0_r, rsp0_flags, rsp0_err}, {m_r[0], m_f[0], m_e[0]});
        chk("rsp1_data", {rsp1_r, rsp1_flags, rsp1_err}, {m_r[1], m_f[1], m_e[1]});
        if (!rst_n) chk("alu_rst", {alu_op, alu_a, alu_b}, 0);
        else if (m_pend && m_age == 0)
            chk("alu_exec", {alu_op, alu_a, alu_b}, (m_op == 4'h0 || m_op == 4'he) ? m_last : {m_op, m_a, m_b});
    end

    // Advance one cycle; drop any valid that handshook, leaving the bench at posedge+1.
    task automatic tick();
        bit h0, h1;
        @(negedge clk);
        h0 = req0_valid && req0_ready;
        h1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
        if (h0) req0_valid = 0;
        if (h1) req1_valid = 0;
        n++;
    endtask

    task automatic wait_rdy(input bit who, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            #3;
            if ((who ? req1_ready : req0_ready) === 1'b1) begin
                at = n;
                return;
            end
            tick();
        end
        chk("ready_timeout", 0, 1);
    endtask

    task automatic set0(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    endtask

    int t0, at, prev, r_n;

    initial begin
        rst_n = 0; rsp0_ready = 1; rsp1_ready = 1;
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        set0(4'h9, 8'h03, 8'h05);
        set1(4'ha, 8'hF0, 8'h0F);
        tick(); tick();
        #3;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1;
        // Both valid at release: req0 first, req1 three cycles later.
        #3; chk("s44_rdy0", req0_ready, 1); chk("s44_rdy1", req1_ready, 0); t0 = n;
        tick(); #3; chk("s44_busy", busy, 1); chk("s44_aluop", alu_op, 4'h9);
        tick(); #3; chk("s44_v0", rsp0_valid, 1); chk("s44_r0", {rsp0_r, rsp0_flags, rsp0_err}, {8'hFE, 3'b100, 1'b0});
        tick(); wait_rdy(1, at); chk("s44_gap", at - t0, 3);
        tick(); tick(); #3; chk("s44_v1", rsp1_valid, 1); chk("s44_r1", {rsp1_r, rsp1_flags, rsp1_err}, {8'h00, 3'b010, 1'b0});
        tick();
        // ADD then illegal op.
        set0(4'h8, 8'h05, 8'h03);
        wait_rdy(0, at);
        tick(); #3; chk("s43_aluop", alu_op, 4'h8); chk("s43_busy1", busy, 1);
        tick(); #3; chk("s43_rsp", {rsp0_valid, rsp0_r, rsp0_flags, rsp0_err}, {1'b1, 8'h08, 3'b000, 1'b0}); chk("s43_busy2", busy, 1);
        tick(); #3; chk("s43_idle", busy, 0);
        tick();
        set0(4'he, 8'h77, 8'h88);
        wait_rdy(0, at);
        tick(); #3; chk("s46_alu", {alu_op, alu_a, alu_b}, {4'h8, 8'h05, 8'h03});
        tick(); #3; chk("s46_rsp", {rsp0_valid, rsp0_r, rsp0_flags, rsp0_err}, {1'b1, 8'h00, 3'b010, 1'b1});
        tick();
        // Back-pressure on rsp1 while req0 waits.
        rsp1_ready = 0;
        set1(4'hc, 8'h3C, 8'hFF);
        wait_rdy(1, at);
        tick();
        set0(4'h8, 8'h01, 8'h02);
        tick(); r_n = n;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("s45_hold", {rsp1_valid, rsp1_r, rsp1_flags, rsp1_err, req0_ready}, {1'b1, 8'hC3, 3'b100, 1'b0, 1'b0});
            tick();
        end
        rsp1_ready = 1;
        #3; chk("s45_last", {rsp1_valid, rsp1_r, req0_ready}, {1'b1, 8'hC3, 1'b0});
        tick();
        wait_rdy(0, at); chk("s45_rel", at - r_n, 6); chk("s45_v1off", rsp1_valid, 0);
        tick();
        // req1 alone, back to back.
        set1(4'hb, 8'h11, 8'h22);
        for (int k = 0; k < 4; k++) begin
            wait_rdy(1, at);
            if (k > 0) chk("s48_gap", at - prev, 3);
            prev = at;
            tick();
            if (k < 3) set1(4'h8 + 4'(k), 8'($urandom), 8'($urandom));
        end
        set0(4'ha, 8'h5A, 8'hFF);
        set1(4'hb, 8'h01, 8'h02);
        wait_rdy(0, at); chk("s48_prio", req1_ready, 0); chk("s48_gap4", at - prev, 3);
        tick();
        // Reset during EXEC of a req1 op.
        wait_rdy(1, at);
        tick();
        #2; rst_n = 0; #1;
        chk("s47_zero", {busy, rsp1_valid, req1_ready, alu_op, alu_a, alu_b, rsp1_r, rsp1_flags, rsp1_err}, 0);
        set1(4'hc, 8'h0F, 8'hF0);
        tick(); rst_n = 1;
        #3; chk("s47_acc", req1_ready, 1);
        tick();
        // Priority returns to RR_INIT after reset.
        set0(4'h8, 8'h10, 8'h20);
        wait_rdy(0, at);
        tick();
        #2; rst_n = 0;
        set0(4'h9, 8'h09, 8'h01);
        set1(4'ha, 8'h09, 8'h01);
        tick(); rst_n = 1;
        #3; chk("rst_prio0", req0_ready, 1); chk("rst_prio1", req1_ready, 0);
        tick();
        for (int i = 0; i < 600; i++) begin
            if (!req0_valid && $urandom_range(1) == 1) set0(4'($urandom), 8'($urandom), 8'($urandom));
            if (!req1_valid && $urandom_range(1) == 1) set1(4'($urandom), 8'($urandom), 8'($urandom));
            rsp0_ready = $urandom_range(3) != 0;
            rsp1_ready = $urandom_range(3) != 0;
            rst_n = $urandom_range(79) != 0;
            tick();
        end
        rst_n = 1;
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
